// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared op and state encodings for the ALU op sequencer
// Purpose: 3-bit ALU op codes, which double as the result mux select, and the
//          sequencer state encoding.
// Ports:   none (package).
package alu_defs;

   localparam logic [2:0] ALU_OP_ADD = 3'b000;
   localparam logic [2:0] ALU_OP_SUB = 3'b001;
   localparam logic [2:0] ALU_OP_AND = 3'b010;
   localparam logic [2:0] ALU_OP_OR  = 3'b011;
   localparam logic [2:0] ALU_OP_XOR = 3'b100;
   localparam logic [2:0] ALU_OP_NOT = 3'b101;
   localparam logic [2:0] ALU_OP_SHL = 3'b110;
   localparam logic [2:0] ALU_OP_SHR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/alu_shift_unit.sv
// rtl/alu_shift_unit.sv - loadable 1-bit-per-clock shift register with sticky overflow
// Purpose: holds the operand being shifted; every enabled clock shifts one bit
//          (zero fill) and ORs the bit falling off the end into a sticky flag.
// Ports:   clock_i, clear_i (sync active-high), load_i/load_data_i (load operand,
//          clear sticky), shift_en_i, dir_right_i (1 = shr, 0 = shl),
//          data_next_o/sticky_next_o (value the register takes at the next edge).
module alu_shift_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clock_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_en_i,
   input  logic             dir_right_i,
   output logic [WIDTH-1:0] data_next_o,
   output logic             sticky_next_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             sticky_q, sticky_d;

   always_comb begin
      data_d   = data_q;
      sticky_d = sticky_q;
      if (load_i) begin
         data_d   = load_data_i;
         sticky_d = 1'b0;
      end else if (shift_en_i) begin
         if (dir_right_i) begin
            data_d   = {1'b0, data_q[WIDTH-1:1]};
            sticky_d = sticky_q | data_q[0];
         end else begin
            data_d   = {data_q[WIDTH-2:0], 1'b0};
            sticky_d = sticky_q | data_q[WIDTH-1];
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (clear_i) begin
         data_q   <= '0;
         sticky_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         sticky_q <= sticky_d;
      end
   end

   // The sequencer captures the result on the same edge as the final shift.
   assign data_next_o   = data_d;
   assign sticky_next_o = sticky_d;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sequences one 8-bit ALU operation per request/response handshake
// Purpose: accepts a request in IDLE, executes add/sub/logic/not in one clock or
//          shl/shr one bit per clock, then holds the response until consumed.
// Ports:   clock, clear (sync active-high); req_valid/req_ready/req_op/req_a/
//          req_b/req_cin request channel; rsp_valid/rsp_ready/rsp_result/rsp_ovf
//          response channel; busy (not IDLE).
//          Build option ALU_FLAGS_EN adds rsp_zero and rsp_neg result flags.
module alu_op_sequencer
   import alu_defs::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = 3
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_ovf,
`ifdef ALU_FLAGS_EN
   output logic             rsp_zero,
   output logic             rsp_neg,
`endif
   output logic             busy
);

   state_t             state_q;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               cin_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic               req_ready_q, busy_q, rsp_valid_q, ovf_q;
   logic [WIDTH-1:0]   result_q;

   logic               accept, req_is_shift, start_shift;
   logic [SHAMT_W-1:0] req_amt;
   logic [WIDTH:0]     wide;
   logic [WIDTH-1:0]   exec_result, shift_next, fin_result;
   logic               exec_ovf, sticky_next, fin_ovf, finish;

   assign accept       = req_valid && req_ready_q;
   assign req_amt      = req_b[SHAMT_W-1:0];
   assign req_is_shift = (req_op == ALU_OP_SHL) || (req_op == ALU_OP_SHR);
   assign start_shift  = accept && req_is_shift && (req_amt != '0);

   alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
      .clock_i      (clock),
      .clear_i      (clear),
      .load_i       (start_shift),
      .load_data_i  (req_a),
      .shift_en_i   (state_q == ST_SHIFT),
      .dir_right_i  (op_q == ALU_OP_SHR),
      .data_next_o  (shift_next),
      .sticky_next_o(sticky_next)
   );

   // Single-cycle ops; carry/borrow come from the extra top bit of the widened sum.
   always_comb begin
      wide        = '0;
      exec_result = '0;
      exec_ovf    = 1'b0;
      case (op_q)
         ALU_OP_ADD: begin
            wide        = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
            exec_result = wide[WIDTH-1:0];
            exec_ovf    = wide[WIDTH];
         end
         ALU_OP_SUB: begin
            wide        = {1'b0, a_q} - {1'b0, b_q};
            exec_result = wide[WIDTH-1:0];
            exec_ovf    = wide[WIDTH];
         end
         ALU_OP_AND: exec_result = a_q & b_q;
         ALU_OP_OR:  exec_result = a_q | b_q;
         ALU_OP_XOR: exec_result = a_q ^ b_q;
         ALU_OP_NOT: exec_result = ~a_q;
         default:    exec_result = a_q;  // shl/shr by zero pass A through
      endcase
   end

   assign finish     = (state_q == ST_EXEC) ||
                       ((state_q == ST_SHIFT) && (cnt_q == SHAMT_W'(1)));
   assign fin_result = (state_q == ST_SHIFT) ? shift_next  : exec_result;
   assign fin_ovf    = (state_q == ST_SHIFT) ? sticky_next : exec_ovf;

`ifdef ALU_FLAGS_EN
   logic zero_q, neg_q;

   always_ff @(posedge clock) begin
      if (clear) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (finish) begin
         zero_q <= (fin_result == '0);
         neg_q  <= fin_result[WIDTH-1];
      end
   end

   assign rsp_zero = zero_q;
   assign rsp_neg  = neg_q;
`endif

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q     <= ST_IDLE;
         op_q        <= ALU_OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         cin_q       <= 1'b0;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q        <= req_op;
                  a_q         <= req_a;
                  b_q         <= req_b;
                  cin_q       <= req_cin;
                  cnt_q       <= req_amt;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= start_shift ? ST_SHIFT : ST_EXEC;
               end
            end
            ST_EXEC, ST_SHIFT: begin
               cnt_q <= cnt_q - SHAMT_W'(1);
               if (finish) begin
                  result_q    <= fin_result;
                  ovf_q       <= fin_ovf;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign busy       = busy_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = result_q;
   assign rsp_ovf    = ovf_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard testbench for alu_op_sequencer
// Purpose: drives requests, predicts each response into a queue and compares
//          result, flags and latency when the response appears.
//          Build with ALU_FLAGS_EN to also exercise rsp_zero/rsp_neg.
module tb_alu_op_sequencer;

   logic       clock = 1'b0;
   logic       clear;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_a, req_b;
   logic       req_cin;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_ovf;
   logic       busy;
`ifdef ALU_FLAGS_EN
   logic       rsp_zero, rsp_neg;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] result;
      logic       ovf;
      logic       zero;
      logic       neg;
      int         lat;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;

   alu_op_sequencer #(.WIDTH(8), .SHAMT_W(3)) dut (
      .clock     (clock),
      .clear     (clear),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_result(rsp_result),
      .rsp_ovf   (rsp_ovf),
`ifdef ALU_FLAGS_EN
      .rsp_zero  (rsp_zero),
      .rsp_neg   (rsp_neg),
`endif
      .busy      (busy)
   );

   function automatic exp_t model(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic cin);
      exp_t e;
      logic [8:0] s;
      int k;
      e.ovf = 1'b0;
      e.lat = 1;
      e.result = 8'h00;
      k = int'(b[2:0]);
      case (op)
         3'd0: begin s = 9'(a) + 9'(b) + 9'(cin); e.result = s[7:0]; e.ovf = s[8]; end
         3'd1: begin e.result = a - b; e.ovf = (a < b); end
         3'd2: e.result = a & b;
         3'd3: e.result = a | b;
         3'd4: e.result = a ^ b;
         3'd5: e.result = ~a;
         3'd6: begin
            e.result = a;
            for (int i = 0; i < k; i++) begin
               e.ovf = e.ovf | e.result[7];
               e.result = e.result << 1;
            end
            if (k > 0) e.lat = k;
         end
         default: begin
            e.result = a;
            for (int i = 0; i < k; i++) begin
               e.ovf = e.ovf | e.result[0];
               e.result = e.result >> 1;
            end
            if (k > 0) e.lat = k;
         end
      endcase
      e.zero = (e.result == 8'h00);
      e.neg  = e.result[7];
      return e;
   endfunction

   // Present a request until accepted; returns #1 after the accept edge.
   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, output bit ok);
      req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (req_ready) ok = 1'b1;
         @(posedge clock); #1;
      end
      req_valid = 1'b0;
      if (ok) sb.push_back(model(op, a, b, cin));
   endtask

   task automatic wait_rsp(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clock); #1;
         lat++;
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      clear = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op = 3'd0; req_a = 8'h00; req_b = 8'h00; req_cin = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      clear = 1'b0;
      checks++;
      if ({rsp_valid, rsp_result, rsp_ovf, busy, req_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: valid=%b result=%h ovf=%b busy=%b ready=%b, required 0 00 0 0 1",
                  rsp_valid, rsp_result, rsp_ovf, busy, req_ready);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if ({rsp_zero, rsp_neg} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags: zero=%b neg=%b, required 0 0", rsp_zero, rsp_neg);
      end
`endif
   endtask

   task automatic run_table(input string name, input logic [2:0] ops[], input logic [7:0] as[],
                            input logic [7:0] bs[], input logic cins[]);
      bit ok;
      int lat;
      exp_t e;
      for (int i = 0; i < ops.size(); i++) begin
         send(ops[i], as[i], bs[i], cins[i], ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL %s_accept[%0d]: req_ready never high, required accept", name, i);
            continue;
         end
         wait_rsp(lat, ok);
         e = sb.pop_front();
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL %s_timeout[%0d]: no rsp_valid, required response", name, i);
            continue;
         end
         checks++;
         if (rsp_result !== e.result || rsp_ovf !== e.ovf || lat != e.lat) begin
            errors++;
            $display("FAIL %s[%0d] op=%0d a=%h b=%h: result=%h ovf=%b lat=%0d, required %h %b %0d",
                     name, i, ops[i], as[i], bs[i], rsp_result, rsp_ovf, lat, e.result, e.ovf, e.lat);
         end
         consume();
      end
   endtask

   task automatic test_arith();
      logic [2:0] ops[]  = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
      logic [7:0] as[]   = '{8'hFF, 8'hFF, 8'h01, 8'hF0, 8'hF0, 8'h3C, 8'h0F, 8'h7F, 8'h80};
      logic [7:0] bs[]   = '{8'h00, 8'hAA, 8'h02, 8'h3C, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'h80};
      logic       cins[] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      run_table("arith", ops, as, bs, cins);
   endtask

   task automatic test_shift();
      logic [2:0] ops[]  = '{3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd7};
      logic [7:0] as[]   = '{8'h81, 8'h0F, 8'hA5, 8'h80, 8'h01, 8'hF3, 8'h5A};
      logic [7:0] bs[]   = '{8'hFB, 8'h04, 8'h08, 8'h07, 8'h07, 8'h02, 8'h00};
      logic       cins[] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      run_table("shift", ops, as, bs, cins);
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      exp_t e;
      send(3'd0, 8'h12, 8'h34, 1'b0, ok);
      wait_rsp(lat, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_first: no response, required response");
      end
      e = sb.pop_front();
      // Queue a second request while the first response is held back.
      req_op = 3'd4; req_a = 8'hAA; req_b = 8'h55; req_cin = 1'b0; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_result !== e.result || rsp_ovf !== e.ovf || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b result=%h ovf=%b ready=%b, required 1 %h %b 0",
                     i, rsp_valid, rsp_result, rsp_ovf, req_ready, e.result, e.ovf);
         end
      end
      sb.push_back(model(3'd4, 8'hAA, 8'h55, 1'b0));
      consume();
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_after_hs: valid=%b ready=%b busy=%b, required 0 1 0", rsp_valid, req_ready, busy);
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_queued_accept: busy=%b ready=%b, required 1 0", busy, req_ready);
      end
      wait_rsp(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || rsp_result !== e.result || rsp_ovf !== e.ovf || lat != 1) begin
         errors++;
         $display("FAIL bp_second: ok=%b result=%h ovf=%b lat=%0d, required 1 %h %b 1",
                  ok, rsp_result, rsp_ovf, lat, e.result, e.ovf);
      end
      consume();
   endtask

   task automatic test_clear();
      bit ok;
      int lat;
      exp_t e;
      send(3'd6, 8'hFF, 8'h05, 1'b0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL clr_accept: req_ready never high, required accept");
      end
      e = sb.pop_front();  // this op is discarded by clear
      repeat (2) @(posedge clock);
      #1;
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      checks++;
      if ({rsp_valid, rsp_result, rsp_ovf, busy, req_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL clr_state: valid=%b result=%h ovf=%b busy=%b ready=%b, required 0 00 0 0 1",
                  rsp_valid, rsp_result, rsp_ovf, busy, req_ready);
      end
      repeat (6) @(posedge clock);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL clr_no_late_rsp: rsp_valid=%b, required 0", rsp_valid);
      end
      send(3'd0, 8'h05, 8'h03, 1'b0, ok);
      wait_rsp(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || rsp_result !== e.result || rsp_ovf !== e.ovf || lat != 1) begin
         errors++;
         $display("FAIL clr_next_add: ok=%b result=%h ovf=%b lat=%0d, required 1 %h %b 1",
                  ok, rsp_result, rsp_ovf, lat, e.result, e.ovf);
      end
      consume();
   endtask

`ifdef ALU_FLAGS_EN
   task automatic test_flags();
      logic [2:0] ops[] = '{3'd4, 3'd5, 3'd6};
      logic [7:0] as[]  = '{8'h23, 8'h0F, 8'h41};
      logic [7:0] bs[]  = '{8'h23, 8'h00, 8'h01};
      bit ok;
      int lat;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         send(ops[i], as[i], bs[i], 1'b0, ok);
         wait_rsp(lat, ok);
         e = sb.pop_front();
         checks++;
         if (!ok || rsp_result !== e.result || rsp_zero !== e.zero || rsp_neg !== e.neg) begin
            errors++;
            $display("FAIL flags[%0d]: ok=%b result=%h zero=%b neg=%b, required 1 %h %b %b",
                     i, ok, rsp_result, rsp_zero, rsp_neg, e.result, e.zero, e.neg);
         end
         consume();
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_arith();
      test_shift();
      test_backpressure();
      test_clear();
`ifdef ALU_FLAGS_EN
      test_flags();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
